// File: rtl/branch_hazard_controller.sv
// Pipeline hazard control: memory stalls, branch/jump redirects and load-use bubbles, plus event counters.
// Latency: control outputs are combinational from state and inputs (0 cycles); counters update on the next edge.
// Backpressure: dmem_ready=0 freezes the whole pipeline and takes priority over every other event.
module branch_hazard_controller #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             PCSel_in,
    input  logic             ex_mem_read,
    input  logic [4:0]       ex_rd,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_rs1_used,
    input  logic             id_rs2_used,
    input  logic             dmem_ready,
    input  logic             cnt_clr,
    output logic             pc_sel_out,
    output logic             stall_pc,
    output logic             stall_ifid,
    output logic             stall_idex,
    output logic             stall_exwb,
    output logic             flush_ifid,
    output logic             flush_idex,
    output logic [CNT_W-1:0] taken_cnt,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam logic [1:0] RUN      = 2'd0;
    localparam logic [1:0] LU       = 2'd1;
    localparam logic [1:0] FLUSH    = 2'd2;
    localparam logic [1:0] MEM_WAIT = 2'd3;

    logic [1:0] state, state_nxt, eval_state;
    logic       flush_pend, flush_pend_nxt;
    logic       luh;
    logic       pc_sel_c, stall_pc_c, stall_ifid_c, stall_idex_c, stall_exwb_c;
    logic       flush_ifid_c, flush_idex_c;

    always_comb begin
        luh = ex_mem_read && (ex_rd != 5'd0) &&
              ((id_rs1_used && (id_rs1 == ex_rd)) || (id_rs2_used && (id_rs2 == ex_rd)));

        // Leaving MEM_WAIT resumes whatever the stall interrupted.
        eval_state = state;
        if (state == MEM_WAIT)
            eval_state = flush_pend ? FLUSH : RUN;

        pc_sel_c       = 1'b0;
        stall_pc_c     = 1'b0;
        stall_ifid_c   = 1'b0;
        stall_idex_c   = 1'b0;
        stall_exwb_c   = 1'b0;
        flush_ifid_c   = 1'b0;
        flush_idex_c   = 1'b0;
        state_nxt      = state;
        flush_pend_nxt = flush_pend;

        if (!dmem_ready) begin
            stall_pc_c     = 1'b1;
            stall_ifid_c   = 1'b1;
            stall_idex_c   = 1'b1;
            stall_exwb_c   = 1'b1;
            state_nxt      = MEM_WAIT;
            flush_pend_nxt = flush_pend || (state == FLUSH);
        end else begin
            flush_pend_nxt = 1'b0;
            case (eval_state)
                FLUSH: begin
                    // Squash the fetch that was already in flight from the old path.
                    flush_ifid_c = 1'b1;
                    state_nxt    = RUN;
                end
                LU: begin
                    if (PCSel_in) begin
                        pc_sel_c     = 1'b1;
                        flush_ifid_c = 1'b1;
                        flush_idex_c = 1'b1;
                        state_nxt    = FLUSH;
                    end else begin
                        state_nxt    = RUN;
                    end
                end
                default: begin
                    if (PCSel_in) begin
                        pc_sel_c     = 1'b1;
                        flush_ifid_c = 1'b1;
                        flush_idex_c = 1'b1;
                        state_nxt    = FLUSH;
                    end else if (luh) begin
                        stall_pc_c   = 1'b1;
                        stall_ifid_c = 1'b1;
                        flush_idex_c = 1'b1;
                        state_nxt    = LU;
                    end else begin
                        state_nxt    = RUN;
                    end
                end
            endcase
        end
    end

    // Gating with rst_n keeps every control output low while reset is held.
    assign pc_sel_out = rst_n & pc_sel_c;
    assign stall_pc   = rst_n & stall_pc_c;
    assign stall_ifid = rst_n & stall_ifid_c;
    assign stall_idex = rst_n & stall_idex_c;
    assign stall_exwb = rst_n & stall_exwb_c;
    assign flush_ifid = rst_n & flush_ifid_c;
    assign flush_idex = rst_n & flush_idex_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= RUN;
            flush_pend <= 1'b0;
        end else begin
            state      <= state_nxt;
            flush_pend <= flush_pend_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            taken_cnt <= '0;
            stall_cnt <= '0;
        end else if (cnt_clr) begin
            taken_cnt <= '0;
            stall_cnt <= '0;
        end else begin
            if (pc_sel_c && (taken_cnt != {CNT_W{1'b1}}))
                taken_cnt <= taken_cnt + CNT_W'(1);
            if (stall_pc_c && (stall_cnt != {CNT_W{1'b1}}))
                stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_branch_hazard_controller.sv
// Bench for branch_hazard_controller: pipeline-level model checked every cycle plus directed scenarios.
module tb_branch_hazard_controller;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          PCSel_in, ex_mem_read, id_rs1_used, id_rs2_used, dmem_ready, cnt_clr;
    logic [4:0]    ex_rd, id_rs1, id_rs2;
    logic          pc_sel_out, stall_pc, stall_ifid, stall_idex, stall_exwb, flush_ifid, flush_idex;
    logic [CW-1:0] taken_cnt, stall_cnt;

    int n_chk = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    branch_hazard_controller #(.CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .PCSel_in(PCSel_in), .ex_mem_read(ex_mem_read),
        .ex_rd(ex_rd), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .dmem_ready(dmem_ready), .cnt_clr(cnt_clr),
        .pc_sel_out(pc_sel_out), .stall_pc(stall_pc), .stall_ifid(stall_ifid),
        .stall_idex(stall_idex), .stall_exwb(stall_exwb),
        .flush_ifid(flush_ifid), .flush_idex(flush_idex),
        .taken_cnt(taken_cnt), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    // {pc_sel, stall_pc, stall_ifid, stall_idex, stall_exwb, flush_ifid, flush_idex}
    logic [6:0] act_ctl;
    assign act_ctl = {pc_sel_out, stall_pc, stall_ifid, stall_idex, stall_exwb, flush_ifid, flush_idex};

    // Model: a stale fetch still owed a squash, and whether the last cycle already paid a load-use bubble.
    logic    bubble_due, lu_block, m_luh;
    logic [6:0] e_ctl;
    int      m_taken, m_stall;
    localparam int CMAX = (1 << CW) - 1;

    always_comb begin
        m_luh = ex_mem_read && ex_rd != 0 &&
                ((id_rs1_used && id_rs1 == ex_rd) || (id_rs2_used && id_rs2 == ex_rd));
        e_ctl = 7'b0000000;
        if (!rst_n)                 e_ctl = 7'b0000000;
        else if (!dmem_ready)       e_ctl = 7'b0111100;
        else if (bubble_due)        e_ctl = 7'b0000010;
        else if (PCSel_in)          e_ctl = 7'b1000011;
        else if (m_luh && !lu_block) e_ctl = 7'b0110001;
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bubble_due <= 1'b0;
            lu_block   <= 1'b0;
            m_taken    <= 0;
            m_stall    <= 0;
        end else begin
            if (!dmem_ready)             lu_block <= 1'b0;
            else if (bubble_due)         begin bubble_due <= 1'b0; lu_block <= 1'b0; end
            else if (PCSel_in)           begin bubble_due <= 1'b1; lu_block <= 1'b0; end
            else if (m_luh && !lu_block) lu_block <= 1'b1;
            else                         lu_block <= 1'b0;
            if (cnt_clr) begin
                m_taken <= 0;
                m_stall <= 0;
            end else begin
                if (e_ctl[6] && m_taken < CMAX) m_taken <= m_taken + 1;
                if (e_ctl[5] && m_stall < CMAX) m_stall <= m_stall + 1;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("model_ctl", 32'(act_ctl), 32'(e_ctl));
            check("model_taken_cnt", 32'(taken_cnt), 32'(m_taken));
            check("model_stall_cnt", 32'(stall_cnt), 32'(m_stall));
        end
    end

    task automatic idle();
        PCSel_in = 0; ex_mem_read = 0; ex_rd = 0; id_rs1 = 0; id_rs2 = 0;
        id_rs1_used = 0; id_rs2_used = 0; dmem_ready = 1; cnt_clr = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_luh();
        ex_mem_read = 1; ex_rd = 5; id_rs1 = 5; id_rs1_used = 1;
    endtask

    task automatic clr_cnts();
        cnt_clr = 1;
        tick();
        cnt_clr = 0;
    endtask

    initial begin
        idle();
        rst_n = 0;
        #2;
        check("reset_ctl", 32'(act_ctl), 32'h0);
        check("reset_taken", 32'(taken_cnt), 32'h0);
        check("reset_stall", 32'(stall_cnt), 32'h0);
        chk_en = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1;
        tick();

        // Load-use bubble, then inputs held unchanged
        set_luh();
        #1 check("lu_cycle1", 32'(act_ctl), 32'h31);
        tick();
        #1 check("lu_cycle2", 32'(act_ctl), 32'h0);
        tick();
        idle();
        #1 check("lu_stall_cnt", 32'(stall_cnt), 32'd1);
        clr_cnts();

        // Redirect
        PCSel_in = 1;
        #1 check("rd_cycle1", 32'(act_ctl), 32'h43);
        tick();
        PCSel_in = 0;
        #1 check("rd_cycle2", 32'(act_ctl), 32'h02);
        tick();
        #1 check("rd_cycle3", 32'(act_ctl), 32'h0);
        check("rd_taken_cnt", 32'(taken_cnt), 32'd1);
        clr_cnts();

        // Redirect wins over a simultaneous load-use
        set_luh();
        PCSel_in = 1;
        #1 check("rd_luh_cycle1", 32'(act_ctl), 32'h43);
        tick();
        PCSel_in = 0;
        #1 check("rd_luh_cycle2", 32'(act_ctl), 32'h02);
        tick();
        idle();
        check("rd_luh_stall_cnt", 32'(stall_cnt), 32'd0);
        clr_cnts();

        // Memory stall landing on the FLUSH cycle
        PCSel_in = 1;
        tick();
        PCSel_in = 0;
        dmem_ready = 0;
        #1 check("mw_stall_c1", 32'(act_ctl), 32'h3C);
        tick();
        tick();
        #1 check("mw_stall_c3", 32'(act_ctl), 32'h3C);
        tick();
        dmem_ready = 1;
        #1 check("mw_resume_flush", 32'(act_ctl), 32'h02);
        tick();
        #1 check("mw_after", 32'(act_ctl), 32'h0);
        check("mw_stall_cnt", 32'(stall_cnt), 32'd3);
        clr_cnts();

        // Saturation: 20 redirects with PCSel held high
        PCSel_in = 1;
        repeat (40) tick();
        check("sat_taken_cnt", 32'(taken_cnt), 32'd15);
        cnt_clr = 1;
        #1 check("clr_redirect_ctl", 32'(act_ctl), 32'h43);
        tick();
        cnt_clr = 0;
        PCSel_in = 0;
        check("clr_over_inc", 32'(taken_cnt), 32'd0);
        tick();

        // Async reset in MEM_WAIT with a squash still owed
        PCSel_in = 1;
        tick();
        PCSel_in = 0;
        dmem_ready = 0;
        tick();
        #1 rst_n = 0;
        #1 check("arst_ctl", 32'(act_ctl), 32'h0);
        check("arst_taken", 32'(taken_cnt), 32'h0);
        check("arst_stall", 32'(stall_cnt), 32'h0);
        dmem_ready = 1;
        tick();
        rst_n = 1;
        #1 check("arst_no_residual", 32'(act_ctl), 32'h0);
        tick();
        set_luh();
        #1 check("arst_run_luh", 32'(act_ctl), 32'h31);
        tick();
        idle();
        tick();
        chk_en = 1'b0;

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
